// File: rtl/etapa_ex.sv
// EX pipeline stage: ID/EX register (A) feeding an external combinational ALU with
// MEM/WB operand forwarding, and an EX/MEM register (B) with a valid/ready handshake.
module etapa_ex #(
    parameter int ANCHO = 32
) (
    input  logic             clk,
    input  logic             reset,
    // decode side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ANCHO-1:0] in_dato1,
    input  logic [ANCHO-1:0] in_dato2,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [2:0]       in_AluOp,
    input  logic             in_RegWrite,
    // forwarding sources
    input  logic             mem_RegWrite,
    input  logic [4:0]       mem_rd,
    input  logic [ANCHO-1:0] mem_dato,
    input  logic             wb_RegWrite,
    input  logic [4:0]       wb_rd,
    input  logic [ANCHO-1:0] wb_dato,
    // external ALU
    output logic [ANCHO-1:0] alu_Ope1,
    output logic [ANCHO-1:0] alu_Ope2,
    output logic [2:0]       alu_AluOp,
    input  logic [ANCHO-1:0] alu_Resultado,
    input  logic             alu_zero,
    // output side
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ANCHO-1:0] out_Resultado,
    output logic             out_zero,
    output logic [4:0]       out_rd,
    output logic             out_RegWrite,
    // control
    input  logic             flush
);

    // Stage A (ID/EX)
    logic             a_valid_q,    a_valid_d;
    logic [ANCHO-1:0] a_dato1_q,    a_dato1_d;
    logic [ANCHO-1:0] a_dato2_q,    a_dato2_d;
    logic [4:0]       a_rs_q,       a_rs_d;
    logic [4:0]       a_rt_q,       a_rt_d;
    logic [4:0]       a_rd_q,       a_rd_d;
    logic [2:0]       a_aluop_q,    a_aluop_d;
    logic             a_regwrite_q, a_regwrite_d;

    // Stage B (EX/MEM)
    logic             b_valid_q,    b_valid_d;
    logic [ANCHO-1:0] b_res_q,      b_res_d;
    logic             b_zero_q,     b_zero_d;
    logic [4:0]       b_rd_q,       b_rd_d;
    logic             b_regwrite_q, b_regwrite_d;

    logic advance;

    // MEM is the younger producer, so it wins over WB; register 0 is never forwarded.
    function automatic logic [ANCHO-1:0] forward_op(
        input logic [4:0]       src,
        input logic [ANCHO-1:0] reg_val,
        input logic             m_we,
        input logic [4:0]       m_rd,
        input logic [ANCHO-1:0] m_dato,
        input logic             w_we,
        input logic [4:0]       w_rd,
        input logic [ANCHO-1:0] w_dato
    );
        logic [ANCHO-1:0] val;
        val = reg_val;
        if (src != 5'd0) begin
            if (m_we && (m_rd == src)) begin
                val = m_dato;
            end else if (w_we && (w_rd == src)) begin
                val = w_dato;
            end
        end
        return val;
    endfunction

    assign advance   = a_valid_q && (!b_valid_q || out_ready);
    assign in_ready  = !a_valid_q || advance;

    assign alu_AluOp = a_aluop_q;
    assign alu_Ope1  = forward_op(a_rs_q, a_dato1_q, mem_RegWrite, mem_rd, mem_dato,
                                  wb_RegWrite, wb_rd, wb_dato);
    assign alu_Ope2  = forward_op(a_rt_q, a_dato2_q, mem_RegWrite, mem_rd, mem_dato,
                                  wb_RegWrite, wb_rd, wb_dato);

    assign out_valid     = b_valid_q;
    assign out_Resultado = b_res_q;
    assign out_zero      = b_zero_q;
    assign out_rd        = b_rd_q;
    assign out_RegWrite  = b_regwrite_q;

    always_comb begin
        a_valid_d    = a_valid_q;
        a_dato1_d    = a_dato1_q;
        a_dato2_d    = a_dato2_q;
        a_rs_d       = a_rs_q;
        a_rt_d       = a_rt_q;
        a_rd_d       = a_rd_q;
        a_aluop_d    = a_aluop_q;
        a_regwrite_d = a_regwrite_q;
        b_valid_d    = b_valid_q;
        b_res_d      = b_res_q;
        b_zero_d     = b_zero_q;
        b_rd_d       = b_rd_q;
        b_regwrite_d = b_regwrite_q;

        // Flush only kills the valid bits; payloads are left as they were.
        if (flush) begin
            a_valid_d = 1'b0;
            b_valid_d = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                a_valid_d    = 1'b1;
                a_dato1_d    = in_dato1;
                a_dato2_d    = in_dato2;
                a_rs_d       = in_rs;
                a_rt_d       = in_rt;
                a_rd_d       = in_rd;
                a_aluop_d    = in_AluOp;
                a_regwrite_d = in_RegWrite;
            end else if (advance) begin
                a_valid_d = 1'b0;
            end

            if (advance) begin
                b_valid_d    = 1'b1;
                b_res_d      = alu_Resultado;
                b_zero_d     = alu_zero;
                b_rd_d       = a_rd_q;
                b_regwrite_d = a_regwrite_q;
            end else if (b_valid_q && out_ready) begin
                b_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_valid_q    <= 1'b0;
            a_dato1_q    <= '0;
            a_dato2_q    <= '0;
            a_rs_q       <= '0;
            a_rt_q       <= '0;
            a_rd_q       <= '0;
            a_aluop_q    <= '0;
            a_regwrite_q <= 1'b0;
            b_valid_q    <= 1'b0;
            b_res_q      <= '0;
            b_zero_q     <= 1'b0;
            b_rd_q       <= '0;
            b_regwrite_q <= 1'b0;
        end else begin
            a_valid_q    <= a_valid_d;
            a_dato1_q    <= a_dato1_d;
            a_dato2_q    <= a_dato2_d;
            a_rs_q       <= a_rs_d;
            a_rt_q       <= a_rt_d;
            a_rd_q       <= a_rd_d;
            a_aluop_q    <= a_aluop_d;
            a_regwrite_q <= a_regwrite_d;
            b_valid_q    <= b_valid_d;
            b_res_q      <= b_res_d;
            b_zero_q     <= b_zero_d;
            b_rd_q       <= b_rd_d;
            b_regwrite_q <= b_regwrite_d;
        end
    end

endmodule
